// File: rtl/sv_job_sequencer.sv
// Job-level sequencer: tracks worker beats for a requested job and reports IDLE/BUSY/DONE/ERROR.
// Define SV_JOB_WATCHDOG_EN to include the beat-less BUSY watchdog (err_cause 10).
//
// state   | meaning
// S_IDLE  | waiting for start
// S_BUSY  | job running, counting beats
// S_DONE  | all beats seen, held until clear
// S_ERROR | zero length / timeout / abort, held until clear
module sv_job_sequencer #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] job_len,
    input  logic             beat,
    input  logic             abort,
    input  logic             clear,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] beats_left,
    output logic             done_pulse,
    output logic [1:0]       err_cause
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BUSY  = 2'b01,
        S_DONE  = 2'b10,
        S_ERROR = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_ZERO  = 2'b01;
    localparam logic [1:0] ERR_WDOG  = 2'b10;
    localparam logic [1:0] ERR_ABORT = 2'b11;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] beats_nxt;
    logic [1:0]       err_nxt;
    logic             done_nxt;

`ifdef SV_JOB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT);
    logic [WD_W-1:0] wd_cnt, wd_nxt;
`endif

    // State encoding doubles as the status code, so status is a register output.
    assign status = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            beats_left <= '0;
            err_cause  <= ERR_NONE;
            done_pulse <= 1'b0;
`ifdef SV_JOB_WATCHDOG_EN
            wd_cnt     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
            err_cause  <= err_nxt;
            done_pulse <= done_nxt;
`ifdef SV_JOB_WATCHDOG_EN
            wd_cnt     <= wd_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        beats_nxt = beats_left;
        err_nxt   = err_cause;
        done_nxt  = 1'b0;
`ifdef SV_JOB_WATCHDOG_EN
        wd_nxt    = wd_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (job_len != '0) begin
                        state_nxt = S_BUSY;
                        beats_nxt = job_len;
`ifdef SV_JOB_WATCHDOG_EN
                        wd_nxt    = '0;
`endif
                    end else begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_ZERO;
                        beats_nxt = '0;
                    end
                end
            end
            S_BUSY: begin
                if (abort) begin
                    state_nxt = S_ERROR;
                    err_nxt   = ERR_ABORT;
                end else if (beat) begin
                    // beats_left is at least 1 in BUSY, so <= 1 also guards against wrap.
                    if (beats_left <= CNT_W'(1)) begin
                        state_nxt = S_DONE;
                        beats_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        beats_nxt = beats_left - CNT_W'(1);
                    end
`ifdef SV_JOB_WATCHDOG_EN
                    wd_nxt = '0;
`endif
                end else begin
`ifdef SV_JOB_WATCHDOG_EN
                    if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        state_nxt = S_ERROR;
                        err_nxt   = ERR_WDOG;
                    end else begin
                        wd_nxt = wd_cnt + WD_W'(1);
                    end
`endif
                end
            end
            S_DONE, S_ERROR: begin
                if (clear) begin
                    state_nxt = S_IDLE;
                    err_nxt   = ERR_NONE;
                    beats_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                err_nxt   = ERR_NONE;
                beats_nxt = '0;
            end
        endcase
    end

endmodule
